// File: rtl/riscv_pkg.sv
// Shared CPU definitions: memory-port arbiter state encoding, grant encoding and
// latency defaults, plus the arbiter's debug view.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int DEFAULT_MEM_LAT = 2;
  localparam int LAT_CNT_W       = 4;

  typedef struct packed {
    arb_state_t           state;
    logic                 last_grant;
    logic [LAT_CNT_W-1:0] count;
  } arb_dbg_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter for multi-cycle units. It stops at zero.
// 'last' marks the final cycle of a loaded interval.
module lat_counter
  import riscv_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign last = (value == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between fetch (IF) and load/store (DM).
// Each access holds mem_en for MEM_LAT cycles, then returns a one-cycle ack.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cpu_stall,
  output arb_dbg_t            dbg
);

  // Handshake: a requester raises x_req and holds it (with stable address/data)
  // until it sees x_ack for one cycle; x_rdata is valid only in that ack cycle.
  // A request still high during its own ack cycle is the old one being dropped.

  arb_state_t           state;
  logic                 last_grant;
  logic                 if_elig, dm_elig;
  logic                 grant_i, grant_d;
  logic                 cnt_load, cnt_last;
  logic [LAT_CNT_W-1:0] cnt_value;

  assign if_elig = if_req & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;

  // DM wins a collision unless it also won the previous grant.
  assign grant_d  = (state == ST_IDLE) & dm_elig & (~if_elig | (last_grant != GRANT_D));
  assign grant_i  = (state == ST_IDLE) & if_elig & ~grant_d;
  assign cnt_load = grant_i | grant_d;

  lat_counter #(.W(LAT_CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_CNT_W'(MEM_LAT)),
    .value    (cnt_value),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state      <= ST_BUSY_D;
            last_grant <= GRANT_D;
            mem_en     <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            mem_be     <= dm_be;
          end else if (grant_i) begin
            state      <= ST_BUSY_I;
            last_grant <= GRANT_I;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (cnt_last) begin
            state     <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if (state == ST_BUSY_I) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              // Stores still acknowledge but leave the last load data in place.
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_ack <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  assign dbg.state      = state;
  assign dbg.last_grant = last_grant;
  assign dbg.count      = cnt_value;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, cpu_stall;
  logic [3:0]  mem_be;
  arb_dbg_t    dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .dbg(dbg)
  );

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h4) return 32'h00500093;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  always_comb mem_rdata = mem_en ? mem_func(mem_addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // behavioural model: one access record with its mem_en window and ack cycle
  bit          a_on = 0;
  bit          a_who;
  int          a_first, a_last;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_we;
  int          if_ack_at = -1, dm_ack_at = -1;
  logic [31:0] m_if_rdata = '0, m_dm_rdata = '0, nx_if_rdata = '0, nx_dm_rdata = '0;
  bit          m_last_d = 0;

  always @(negedge clk) begin : model
    bit in_acc, e_ia, e_da, if_e, dm_e, pick_d;
    cyc++;
    if (!rst) begin
      a_on = 0; if_ack_at = -1; dm_ack_at = -1;
      m_if_rdata = '0; m_dm_rdata = '0; m_last_d = 0;
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_if_ack", 32'(if_ack), 32'd0);
      check("rst_dm_ack", 32'(dm_ack), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
    end else begin
      in_acc = a_on && (cyc >= a_first) && (cyc <= a_last);
      e_ia = (cyc == if_ack_at);
      e_da = (cyc == dm_ack_at);
      if (e_ia) m_if_rdata = nx_if_rdata;
      if (e_da) m_dm_rdata = nx_dm_rdata;
      check("mem_en", 32'(mem_en), 32'(in_acc));
      check("mem_we", 32'(mem_we), 32'(in_acc & a_who & a_we));
      check("mem_addr", mem_addr, in_acc ? a_addr : 32'h0);
      check("mem_wdata", mem_wdata, (in_acc && a_who) ? a_wdata : 32'h0);
      check("mem_be", 32'(mem_be), (in_acc && a_who) ? 32'(a_be) : 32'h0);
      check("if_ack", 32'(if_ack), 32'(e_ia));
      check("dm_ack", 32'(dm_ack), 32'(e_da));
      check("if_rdata", if_rdata, m_if_rdata);
      check("dm_rdata", dm_rdata, m_dm_rdata);
      check("cpu_stall", 32'(cpu_stall), 32'((if_req & ~e_ia) | (dm_req & ~e_da)));
      if (in_acc && cyc == a_last) begin
        if (a_who) begin
          dm_ack_at = cyc + 1;
          nx_dm_rdata = a_we ? m_dm_rdata : mem_func(a_addr);
        end else begin
          if_ack_at = cyc + 1;
          nx_if_rdata = mem_func(a_addr);
        end
      end
      if (!in_acc) begin
        if_e = if_req & ~e_ia;
        dm_e = dm_req & ~e_da;
        if (if_e || dm_e) begin
          pick_d  = dm_e && (!if_e || !m_last_d);
          a_on    = 1;
          a_who   = pick_d;
          a_first = cyc + 1;
          a_last  = cyc + LAT;
          a_addr  = pick_d ? dm_addr : if_addr;
          a_we    = pick_d ? dm_we : 1'b0;
          a_wdata = pick_d ? dm_wdata : 32'h0;
          a_be    = pick_d ? dm_be : 4'h0;
          m_last_d = pick_d;
        end
      end
    end
  end

  // scoreboard for ack ordering: 2'b10 = DM, 2'b01 = IF
  logic [1:0] exp_q[$];
  bit         log_en = 0;

  always @(negedge clk) begin : ack_sb
    logic [1:0] e;
    if (rst && log_en && (if_ack || dm_ack)) begin
      if (exp_q.size() == 0) begin
        check("ack_order_extra", 32'({dm_ack, if_ack}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_order", 32'({dm_ack, if_ack}), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit d);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(d ? dm_ack : if_ack) && t < 40);
    check(d ? "dm_ack_wait" : "if_ack_wait", 32'(d ? dm_ack : if_ack), 32'd1);
  endtask

  task automatic dm_run(input int n, input logic we, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      dm_we    = we;
      dm_addr  = base + 32'(k * 4);
      dm_wdata = $urandom;
      dm_be    = 4'($urandom_range(1, 15));
      dm_req   = 1'b1;
      wait_ack(1'b1);
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
  endtask

  task automatic if_run(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      if_addr = base + 32'(k * 4);
      if_req  = 1'b1;
      wait_ack(1'b0);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0;
    idle(2);
    @(negedge clk);
    check("lit_rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("lit_rst_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    idle(2);

    // fetch only; address changes mid-access must be ignored
    if_addr = 32'h4; if_req = 1'b1;
    @(negedge clk);
    check("lit_f_c0_en", 32'(mem_en), 32'd0);
    check("lit_f_c0_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1; if_addr = 32'h8;
    @(negedge clk);
    check("lit_f_c1_en", 32'(mem_en), 32'd1);
    check("lit_f_c1_addr", mem_addr, 32'h4);
    check("lit_f_c1_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("lit_f_c2_en", 32'(mem_en), 32'd1);
    check("lit_f_c2_addr", mem_addr, 32'h4);
    @(negedge clk);
    check("lit_f_c3_ack", 32'(if_ack), 32'd1);
    check("lit_f_c3_rdata", if_rdata, 32'h00500093);
    check("lit_f_c3_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;
    idle(2);

    // store
    dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lit_s_c1_we", 32'(mem_we), 32'd1);
    check("lit_s_c1_addr", mem_addr, 32'h100);
    check("lit_s_c1_wdata", mem_wdata, 32'hDEADBEEF);
    check("lit_s_c1_be", 32'(mem_be), 32'h3);
    @(negedge clk);
    check("lit_s_c2_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    check("lit_s_c3_ack", 32'(dm_ack), 32'd1);
    check("lit_s_c3_rdata", dm_rdata, 32'h0);
    @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0;
    idle(2);

    // collision after a DM grant: IF goes first
    if_addr = 32'h10; if_req = 1'b1;
    dm_addr = 32'h20; dm_we = 1'b0; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lit_rr_c1_addr", mem_addr, 32'h10);
    @(negedge clk);
    @(negedge clk);
    check("lit_rr_c3_if_ack", 32'(if_ack), 32'd1);
    check("lit_rr_c3_dm_ack", 32'(dm_ack), 32'd0);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("lit_rr_c6_dm_ack", 32'(dm_ack), 32'd1);
    check("lit_rr_c6_rdata", dm_rdata, 32'hA5850020);
    @(posedge clk); #1; dm_req = 1'b0;
    idle(2);

    // reset in the first cycle of a load
    dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("lit_ra_c1_en", 32'(mem_en), 32'd0);
    check("lit_ra_c1_state", 32'(dbg.state), 32'(ST_IDLE));
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("lit_ra_c3_ack", 32'(dm_ack), 32'd0);
    @(negedge clk);
    check("lit_ra_c4_addr", mem_addr, 32'h200);
    @(negedge clk);
    @(negedge clk);
    check("lit_ra_c6_ack", 32'(dm_ack), 32'd1);
    check("lit_ra_c6_rdata", dm_rdata, 32'hA7A50200);
    @(posedge clk); #1; dm_req = 1'b0;
    idle(2);

    // collision straight after reset: DM first
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    dm_addr = 32'h40; dm_we = 1'b0; dm_req = 1'b1;
    if_addr = 32'h44; if_req = 1'b1;
    repeat (4) @(negedge clk);
    check("lit_co_c3_dm_ack", 32'(dm_ack), 32'd1);
    check("lit_co_c3_if_ack", 32'(if_ack), 32'd0);
    @(posedge clk); #1; dm_req = 1'b0;
    @(negedge clk);
    check("lit_co_c4_addr", mem_addr, 32'h44);
    @(negedge clk);
    @(negedge clk);
    check("lit_co_c6_if_ack", 32'(if_ack), 32'd1);
    check("lit_co_c6_rdata", if_rdata, 32'hA5E10044);
    @(posedge clk); #1; if_req = 1'b0;
    idle(2);

    // back-to-back loads against continuous fetch
    exp_q = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    log_en = 1;
    fork
      dm_run(3, 1'b0, 32'h300);
      if_run(2, 32'h80);
    join
    idle(2);
    log_en = 0;
    check("ack_order_left", 32'(exp_q.size()), 32'd0);

    // ack-cycle drop: request still high in its ack cycle is not re-granted
    dm_addr = 32'h500; dm_we = 1'b0; dm_req = 1'b1;
    repeat (4) @(negedge clk);
    check("lit_ad_c3_ack", 32'(dm_ack), 32'd1);
    @(posedge clk); #1; dm_req = 1'b0;
    @(negedge clk);
    check("lit_ad_c4_en", 32'(mem_en), 32'd0);
    check("lit_ad_c4_state", 32'(dbg.state), 32'(ST_IDLE));
    idle(2);

    // mixed stores and fetches
    fork
      dm_run(4, 1'b1, 32'h600);
      if_run(3, 32'hC0);
    join
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
